// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the single-clock FIFO family.
package fifo_pkg;

  // Registered status flags, kept together so they reset and update as one.
  typedef struct packed {
    logic wfull;
    logic wafull;
    logic rempty;
    logic raempty;
  } fifo_flags_t;

  // Checks that the thresholds fit the configured depth.
  function automatic bit thr_ok(input int aw, input int afn, input int aen);
    return (aw >= 1) && (afn >= 0) && (afn <= (1 << aw)) &&
           (aen >= 0) && (aen < (1 << aw));
  endfunction

endpackage

// File: rtl/sfifo_ctrl.sv
// Pointer, occupancy, flag and sticky-error bookkeeping for sfifo.
module sfifo_ctrl
  import fifo_pkg::*;
#(
  parameter int AW  = 4,
  parameter int AFN = 2**AW-4,
  parameter int AEN = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          we,
  input  logic          re,
  output logic          wt,
  output logic          rd,
  output logic [AW-1:0] wptr,
  output logic [AW-1:0] rptr,
  output logic [AW:0]   num,
  output logic          wfull,
  output logic          wafull,
  output logic          rempty,
  output logic          raempty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(2**AW);
  localparam logic [AW:0] AFN_W   = (AW+1)'(AFN);
  localparam logic [AW:0] AEN_W   = (AW+1)'(AEN);
  localparam fifo_flags_t FLAGS_RST = '{
    wfull:   1'b0,
    wafull:  (AFN == 0) ? 1'b1 : 1'b0,
    rempty:  1'b1,
    raempty: 1'b1
  };

  generate
    if (!thr_ok(AW, AFN, AEN)) begin : g_thr_bad
      $fatal(1, "sfifo_ctrl: AFN/AEN out of range for AW");
    end
  endgenerate

  logic [AW-1:0] wptr_reg;
  logic [AW-1:0] rptr_reg;
  logic [AW:0]   num_reg;
  logic [AW:0]   num_next;
  fifo_flags_t   flags_reg;
  fifo_flags_t   flags_next;
  logic          overflow_reg;
  logic          underflow_reg;

  // Acceptance is judged on this cycle's registered flags; flush blocks both sides.
  always_comb begin
    wt = we & ~flags_reg.wfull  & ~clr;
    rd = re & ~flags_reg.rempty & ~clr;
    num_next = num_reg + {{AW{1'b0}}, wt} - {{AW{1'b0}}, rd};
    flags_next.wfull   = (num_next == DEPTH_W);
    flags_next.wafull  = (num_next >= AFN_W);
    flags_next.rempty  = (num_next == '0);
    flags_next.raempty = (num_next <= AEN_W);
  end

  // State update: flush restores the reset picture, errors are sticky otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      num_reg       <= '0;
      flags_reg     <= FLAGS_RST;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clr) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      num_reg       <= '0;
      flags_reg     <= FLAGS_RST;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wt) wptr_reg <= wptr_reg + 1'b1;
      if (rd) rptr_reg <= rptr_reg + 1'b1;
      num_reg   <= num_next;
      flags_reg <= flags_next;
      if (we & flags_reg.wfull)  overflow_reg  <= 1'b1;
      if (re & flags_reg.rempty) underflow_reg <= 1'b1;
    end
  end

  assign wptr      = wptr_reg;
  assign rptr      = rptr_reg;
  assign num       = num_reg;
  assign wfull     = flags_reg.wfull;
  assign wafull    = flags_reg.wafull;
  assign rempty    = flags_reg.rempty;
  assign raempty   = flags_reg.raempty;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: rtl/sfifo.sv
// Single-clock FIFO: storage array plus registered or fall-through read path.
module sfifo
  import fifo_pkg::*;
#(
  parameter int AW   = 4,
  parameter int DW   = 32,
  parameter int AFN  = 2**AW-4,
  parameter int AEN  = 1,
  parameter int FWFT = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          we,
  input  logic [DW-1:0] d,
  input  logic          re,
  output logic [DW-1:0] q,
  output logic          wfull,
  output logic          wafull,
  output logic          rempty,
  output logic          raempty,
  output logic [AW:0]   num,
  output logic          overflow,
  output logic          underflow
);

  logic          wt;
  logic          rd;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [DW-1:0] mem_reg [2**AW];
  logic [DW-1:0] head;
  logic [DW-1:0] q_reg;

  sfifo_ctrl #(
    .AW  (AW),
    .AFN (AFN),
    .AEN (AEN)
  ) u_ctrl (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .we        (we),
    .re        (re),
    .wt        (wt),
    .rd        (rd),
    .wptr      (wptr),
    .rptr      (rptr),
    .num       (num),
    .wfull     (wfull),
    .wafull    (wafull),
    .rempty    (rempty),
    .raempty   (raempty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Write port; contents survive flush and reset, the pointers make them unreachable.
  always_ff @(posedge clk) begin
    if (wt) mem_reg[wptr] <= d;
  end

  assign head = mem_reg[rptr];

  // Registered read data: loads the head on an accepted pop, cleared by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q_reg <= '0;
    else if (clr)  q_reg <= '0;
    else if (rd)   q_reg <= head;
  end

  assign q = (FWFT != 0) ? head : q_reg;

endmodule

// File: doc/sfifo.md
# sfifo

Parametrised single-clock FIFO, the synchronous successor to the dual-clock FIFO wrapper. Used wherever producer and consumer share one clock, such as AXI slave data buffering and descriptor queues. It adds programmable almost-full and almost-empty thresholds, a selectable first-word-fall-through (FWFT) or registered-read mode, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags. Depth is 2**AW; all flags are registered.

## Interface
- AW, 4, log2(depth), ≥1; capacity is 2**AW words
- DW, 32, data width, ≥1
- AFN, 2**AW-4, almost-full threshold; wafull=1 when num ≥ AFN
- AEN, 1, almost-empty threshold; raempty=1 when num ≤ AEN
- FWFT, 0, 0: registered read (q updates the cycle after an accepted read); 1: fall-through (q shows the head word while rempty=0)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush
- we  in  1  write request
- d  in  DW  write data
- re  in  1  read request / pop
- q  out  DW  read data
- wfull  out  1  full
- wafull  out  1  almost full
- rempty  out  1  empty
- raempty  out  1  almost empty
- num  out  AW+1  occupancy, 0..2**AW
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Storage: 2**AW×DW array. Write port is clocked; read port is combinational.
- Pointers: wptr and rptr are AW bits and wrap modulo 2**AW. num is kept as a separate AW+1-bit counter.
- Accepted write: wt = we & ~wfull. Accepted read: rd = re & ~rempty. Acceptance is judged against the registered flags of the current cycle.
- Next count: num_nx = num + wt − rd.
- Next flags, all registered from num_nx:
  - wfull  = (num_nx == 2**AW)
  - rempty = (num_nx == 0)
  - wafull = (num_nx ≥ AFN)
  - raempty = (num_nx ≤ AEN)
- Full with we&re: the read is accepted, the write is rejected, overflow sets. num drops by 1.
- Empty with we&re: the write is accepted, the read is rejected, underflow sets. num becomes 1.
- Non-boundary we&re: both are accepted and num is unchanged.
- FWFT=0: on rd, q <= mem[rptr]. q holds its value otherwise.
- FWFT=1: q = mem[rptr] combinationally. The value is valid only while rempty=0. re pops the current head.
- clr has priority over we and re. On clr:
  - wptr, rptr and num go to 0
  - flags go to their reset values
  - overflow and underflow clear
  - in FWFT=0, q goes to 0
  - array contents are left untouched
- The sticky error flags clear only on reset_n or clr.

## Timing
- Reset values: q=0 (FWFT=0), num=0, wfull=0, wafull=(AFN==0), rempty=1, raempty=1, overflow=0, underflow=0.
- Write-to-read latency: a write in cycle N to an empty FIFO gives rempty=0 at N+1.
  - FWFT=1: q is valid at N+1.
  - FWFT=0: re at N+1 gives q at N+2.
- A read freeing the last slot in cycle N gives wfull=0 at N+1. A write in that same cycle N is still rejected.
- Flags, num and the error flags change only on a clk edge or on reset_n assertion.
- reset_n asserted mid-burst takes effect immediately and asynchronously. Nothing written before it is readable afterwards.
- Back-to-back operation: one write and one read can be accepted every cycle with no bubbles.

## Structure
- Shared package fifo_pkg holds:
  - typedef fifo_flags_t: packed struct {wfull, wafull, rempty, raempty}
  - function thr_ok(): elaboration-time check that AFN ≤ 2**AW and AEN < 2**AW; a violation is a $fatal
- Sub-module sfifo_ctrl holds pointers, count, flags and error logic (AW, AFN, AEN).
- Top sfifo holds the memory array and the q path for both FWFT modes. Target 150–250 lines total.

## Test plan
- AW=2, DW=8, AFN=3, AEN=1, FWFT=0. Write 0x11,0x22,0x33,0x44 in consecutive cycles.
  - num steps 1,2,3,4.
  - wafull rises with num=3; wfull rises with num=4.
  - A fifth write of 0x55 sets overflow; num stays 4.
- From full, pulse re four times.
  - q = 0x11,0x22,0x33,0x44, each one cycle after its re.
  - rempty=1 after the last read.
  - A further re sets underflow; q holds 0x44.
- FWFT=1, empty. Write 0xA5 in cycle N.
  - rempty=0 and q=0xA5 at N+1.
  - re at N+1 gives rempty=1 and num=0 at N+2.
- Full FIFO with we&re together for 3 cycles.
  - Reads accepted and writes rejected in the first cycle only; num goes 4→3.
  - Both accepted in the following cycles; num stays 3.
  - overflow=1 from the first cycle.
- Fill 3 entries with overflow set, then pulse clr with we=1.
  - Next cycle: num=0, rempty=1, raempty=1, overflow=0; the write is ignored.
- Random we/re for 10k cycles against a queue model.
  - q order and num match the model.
  - wptr and rptr wrap many times.
  - reset_n pulses asynchronously mid-traffic and the state returns to reset values.
